// File: rtl/flag_pattern_top.sv
// ============================================================================
//  Module   : flag_pattern_top
//  Purpose  : 10-output pattern generator for an indicator bank. A 2-bit
//             mode input selects off / running light / alternating blink /
//             ping-pong dot. Patterns advance on a prescaled step tick.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DIV    clock cycles per pattern step (1..65535)
//  Ports
//    clk    in   1   system clock, rising edge
//    rst_n  in   1   asynchronous active-low reset
//    flag   in   2   mode select: 0 off, 1 running, 2 blink, 3 ping-pong
//    out    out  10  registered pattern outputs, out[i] drives indicator i
//  Build option
//    FLAG_SYNC_EN  when defined, flag passes through a 2-flop synchronizer
//                  (reset to 0) before the mode compare; the new start
//                  pattern then appears 3 cycles after a flag change.
// ============================================================================
`default_nettype none

module flag_pattern_top #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] flag,
    output logic [9:0] out
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PING  = 2'd3
    } mode_t;

    localparam logic [15:0] C_DIV_LAST   = 16'(DIV - 1);
    localparam logic [9:0]  C_PAT_OFF    = 10'h000;
    localparam logic [9:0]  C_PAT_RUN    = 10'h001;
    localparam logic [9:0]  C_PAT_BLINK  = 10'h155;
    localparam logic [3:0]  C_POS_LAST   = 4'd9;

    // Mode value used for the compare, optionally synchronized
    logic [1:0] flag_s;

`ifdef FLAG_SYNC_EN
    logic [1:0] sync_1;
    logic [1:0] sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 2'd0;
            sync_2 <= 2'd0;
        end else begin
            sync_1 <= flag;
            sync_2 <= sync_1;
        end
    end

    assign flag_s = sync_2;
`else
    assign flag_s = flag;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    mode_t       mode_q,  mode_d;
    logic [15:0] presc_q, presc_d;
    logic [3:0]  pos_q,   pos_d;
    logic        down_q,  down_d;   // 0 = moving up, 1 = moving down
    logic [9:0]  out_q,   out_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            presc_q <= 16'd0;
            pos_q   <= 4'd0;
            down_q  <= 1'b0;
            out_q   <= C_PAT_OFF;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
            pos_q   <= pos_d;
            down_q  <= down_d;
            out_q   <= out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic mode_change;
    logic tick;

    always_comb begin
        mode_change = (mode_t'(flag_s) != mode_q);
        tick        = (presc_q == C_DIV_LAST);

        mode_d  = mode_q;
        presc_d = presc_q;
        pos_d   = pos_q;
        down_d  = down_q;
        out_d   = out_q;

        if (mode_change) begin
            // A mode change always wins over a coincident step tick
            mode_d  = mode_t'(flag_s);
            presc_d = 16'd0;
            pos_d   = 4'd0;
            down_d  = 1'b0;
            case (mode_t'(flag_s))
                MODE_OFF:   out_d = C_PAT_OFF;
                MODE_RUN:   out_d = C_PAT_RUN;
                MODE_BLINK: out_d = C_PAT_BLINK;
                MODE_PING:  out_d = C_PAT_RUN;
                default:    out_d = C_PAT_OFF;
            endcase
        end else if (mode_q == MODE_OFF) begin
            presc_d = 16'd0;
            out_d   = C_PAT_OFF;
        end else begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            if (tick) begin
                case (mode_q)
                    MODE_RUN:   out_d = {out_q[8:0], out_q[9]};
                    MODE_BLINK: out_d = ~out_q;
                    MODE_PING: begin
                        // Direction flips on reaching an end so the end
                        // position is shown for exactly one step.
                        if (!down_q) begin
                            if (pos_q == C_POS_LAST) begin
                                pos_d  = pos_q - 4'd1;
                                down_d = 1'b1;
                            end else begin
                                pos_d  = pos_q + 4'd1;
                            end
                        end else begin
                            if (pos_q == 4'd0) begin
                                pos_d  = 4'd1;
                                down_d = 1'b0;
                            end else begin
                                pos_d  = pos_q - 4'd1;
                            end
                        end
                        out_d = 10'd1 << pos_d;
                    end
                    default:    out_d = C_PAT_OFF;
                endcase
            end
        end
    end

    assign out = out_q;

endmodule

`default_nettype wire

// File: tb/tb_flag_pattern_top.sv
`default_nettype none

module tb_flag_pattern_top;

    localparam int DIV = 4;
`ifdef FLAG_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] flag;
    logic [9:0] out;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q[$];

    flag_pattern_top #(.DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flag  (flag),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the number of steps taken since the last
    // start-pattern load and derives the pattern from that count.
    // ------------------------------------------------------------------
    int         m_mode  = 0;
    int         m_cnt   = 0;
    int         m_steps = 0;
    logic [1:0] m_s1    = 2'd0;
    logic [1:0] m_s2    = 2'd0;

    function automatic logic [9:0] pattern(input int mode, input int steps);
        int p;
        case (mode)
            1:       return 10'(1 << (steps % 10));
            2:       return (steps % 2 == 0) ? 10'h155 : 10'h2AA;
            3: begin
                p = steps % 18;
                return 10'(1 << ((p <= 9) ? p : 18 - p));
            end
            default: return 10'h000;
        endcase
    endfunction

    always @(posedge clk) begin
        int fe;
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_steps = 0; m_s1 = 2'd0; m_s2 = 2'd0;
        end else begin
`ifdef FLAG_SYNC_EN
            fe   = int'(m_s2);
            m_s2 = m_s1;
            m_s1 = flag;
`else
            fe   = int'(flag);
`endif
            if (fe != m_mode) begin
                m_mode = fe; m_cnt = 0; m_steps = 0;
            end else if (m_mode != 0) begin
                m_cnt++;
                if (m_cnt == DIV) begin
                    m_cnt = 0;
                    m_steps++;
                end
            end
        end
        exp_q.push_back(pattern(m_mode, m_steps));
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0)
            check_eq("model", out, exp_q.pop_front());
    end

    // Advance n cycles; returns just after the checker's negedge sample
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        flag  = 2'd0;

        // 1. asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check_eq("reset_async", out, 10'h000);
        cycles(2);
        rst_n = 1'b1;
        cycles(20);
        check_eq("off_hold", out, 10'h000);

        // 2. running light
        flag = 2'd1;
        cycles(LAT);
        check_eq("run_start", out, 10'h001);
        cycles(DIV);
        check_eq("run_step1", out, 10'h002);
        cycles(8 * DIV);
        check_eq("run_step9", out, 10'h200);
        cycles(DIV);
        check_eq("run_wrap", out, 10'h001);

        // 3. blink
        flag = 2'd2;
        cycles(LAT);
        check_eq("blink_start", out, 10'h155);
        cycles(DIV);
        check_eq("blink_step1", out, 10'h2AA);
        cycles(DIV);
        check_eq("blink_step2", out, 10'h155);

        // 4. ping-pong
        flag = 2'd3;
        cycles(LAT);
        check_eq("ping_start", out, 10'h001);
        cycles(9 * DIV);
        check_eq("ping_step9", out, 10'h200);
        cycles(DIV);
        check_eq("ping_step10", out, 10'h100);
        cycles(8 * DIV);
        check_eq("ping_step18", out, 10'h001);
        cycles(DIV);
        check_eq("ping_step19", out, 10'h002);

        // 5. mode change coinciding with the step tick
        flag = 2'd1;
        cycles(LAT);
        check_eq("run_restart", out, 10'h001);
        cycles(DIV - 1 - (LAT - 1));
        flag = 2'd3;
        cycles(LAT);
        check_eq("chg_on_tick", out, 10'h001);
        cycles(DIV);
        check_eq("chg_presc_restart", out, 10'h002);
        flag = 2'd1;
        cycles(2);
        flag = 2'd3;
        cycles(LAT + 1);
        flag = 2'd0;
        cycles(LAT);
        check_eq("to_off", out, 10'h000);

        // 6. reset mid-pattern in ping-pong
        flag = 2'd3;
        cycles(LAT + 6 * DIV);
        check_eq("ping_pos6", out, 10'h040);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_mid", out, 10'h000);
        cycles(2);
        rst_n = 1'b1;
        cycles(LAT);
        check_eq("post_reset_start", out, 10'h001);
        cycles(DIV);
        check_eq("post_reset_up", out, 10'h002);

        // Random mode changes, rewrites and holds, checked by the model
        for (int i = 0; i < 60; i++) begin
            flag = 2'($urandom_range(0, 3));
            cycles($urandom_range(1, 3 * DIV + 2));
        end
        cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
